// File: rtl/mmio_bridge_if.sv
// CPU-side request bus and SRAM-side memory bus of the MMIO bridge.
interface mmio_bridge_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_mem_ena;
  logic              cpu_wr_ena;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_mem_ena;
  logic              sram_wr_ena;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  // CPU and SRAM model side
  modport master (
    output cpu_addr, cpu_mem_ena, cpu_wr_ena, cpu_wdata, sram_rdata,
    input  cpu_rdata, cpu_ready, sram_addr, sram_mem_ena, sram_wr_ena, sram_wdata
  );

  // Bridge side
  modport slave (
    input  cpu_addr, cpu_mem_ena, cpu_wr_ena, cpu_wdata, sram_rdata,
    output cpu_rdata, cpu_ready, sram_addr, sram_mem_ena, sram_wr_ena, sram_wdata
  );
endinterface

// File: rtl/mmio_bridge.sv
// Routes single CPU accesses either to an SRAM port or to a small MMIO
// block (hex display registers + switch input) in the top 16 addresses.
module mmio_bridge #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned N_HEX    = 2,
  parameter int unsigned SRAM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  mmio_bridge_if.slave            bus,
  input  logic [DATA_W-1:0]       sw_i,
  output logic [N_HEX*DATA_W-1:0] hex_o
);

  localparam int unsigned CNT_W = 3;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SRAM_RD = 3'd1;
  localparam logic [2:0] SRAM_WR = 3'd2;
  localparam logic [2:0] MMIO    = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             wr_q;
  logic             is_mmio_c;
  logic [3:0]       off_c;
  logic [DATA_W-1:0] mmio_rdata_c;

  // Region decode uses the live request; the offset uses the latched address.
  assign is_mmio_c = &bus.cpu_addr[ADDR_W-1:4];
  assign off_c     = bus.sram_addr[3:0];

  // MMIO read source: offset 15 is the switches, k < N_HEX a hex register, else 0
  always_comb begin
    mmio_rdata_c = '0;
    if (off_c == 4'hF) begin
      mmio_rdata_c = sw_i;
    end else begin
      for (int unsigned k = 0; k < N_HEX; k++) begin
        if (off_c == 4'(k)) mmio_rdata_c = hex_o[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic and SRAM read wait counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.cpu_mem_ena) begin
          cnt_nxt = '0;
          if (is_mmio_c)           state_nxt = MMIO;
          else if (bus.cpu_wr_ena) state_nxt = SRAM_WR;
          else                     state_nxt = SRAM_RD;
        end
      end
      SRAM_RD: begin
        if (cnt == CNT_W'(SRAM_LAT - 1)) state_nxt = DONE;
        else                             cnt_nxt   = cnt + CNT_W'(1);
      end
      SRAM_WR: state_nxt = DONE;
      MMIO:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, registered strobes (derived from next state so they align with the state), datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      wr_q             <= 1'b0;
      bus.cpu_ready    <= 1'b0;
      bus.cpu_rdata    <= '0;
      bus.sram_mem_ena <= 1'b0;
      bus.sram_wr_ena  <= 1'b0;
      bus.sram_addr    <= '0;
      bus.sram_wdata   <= '0;
      hex_o            <= '0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      bus.cpu_ready    <= (state_nxt == DONE);
      bus.sram_mem_ena <= (state_nxt == SRAM_RD) || (state_nxt == SRAM_WR);
      bus.sram_wr_ena  <= (state_nxt == SRAM_WR);
      if (state == IDLE && bus.cpu_mem_ena) begin
        bus.sram_addr  <= bus.cpu_addr;
        bus.sram_wdata <= bus.cpu_wdata;
        wr_q           <= bus.cpu_wr_ena;
      end
      if (state == SRAM_RD && state_nxt == DONE) bus.cpu_rdata <= bus.sram_rdata;
      if (state == MMIO && !wr_q)                bus.cpu_rdata <= mmio_rdata_c;
      if (state == MMIO && wr_q) begin
        for (int unsigned k = 0; k < N_HEX; k++) begin
          if ((off_c == 4'(k)) || (off_c == 4'hF && k == 0))
            hex_o[k*DATA_W +: DATA_W] <= bus.sram_wdata;
        end
      end
    end
  end

endmodule

// File: doc/mmio_bridge.md
MMIO_BRIDGE -- requirements
Module: mmio_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning data bus width in bits.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning address bus width in bits (>=8).
REQ-003 SHALL have parameter N_HEX, default 2, meaning number of R/W hex display registers (1..15).
REQ-004 SHALL have parameter SRAM_LAT, default 1, meaning SRAM read wait cycles (1..7).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port cpu_addr  input  ADDR_W  CPU request address.
REQ-008 SHALL have port cpu_mem_ena  input  1  CPU request valid.
REQ-009 SHALL have port cpu_wr_ena  input  1  1 = write, 0 = read; qualified by cpu_mem_ena.
REQ-010 SHALL have port cpu_wdata  input  DATA_W  CPU write data.
REQ-011 SHALL have port cpu_rdata  output  DATA_W  registered read data.
REQ-012 SHALL have port cpu_ready  output  1  one-cycle completion pulse.
REQ-013 SHALL have port sram_addr  output  ADDR_W  SRAM address.
REQ-014 SHALL have port sram_mem_ena  output  1  SRAM enable.
REQ-015 SHALL have port sram_wr_ena  output  1  SRAM write strobe.
REQ-016 SHALL have port sram_wdata  output  DATA_W  SRAM write data.
REQ-017 SHALL have port sram_rdata  input  DATA_W  SRAM read data.
REQ-018 SHALL have port sw_i  input  DATA_W  switches, already synchronized upstream.
REQ-019 SHALL have port hex_o  output  N_HEX*DATA_W  hex registers; reg k at bits [k*DATA_W +: DATA_W].

Function
REQ-020 SHALL decode MMIO region as cpu_addr[ADDR_W-1:4] all ones; offset = cpu_addr[3:0]; all other addresses map to SRAM.
REQ-021 SHALL map offset k < N_HEX to hex register k (read/write); offset 15: read returns sw_i, write updates hex register 0.
REQ-022 SHALL treat offsets N_HEX..14 as unmapped: reads return 0, writes dropped, cpu_ready still pulses.
REQ-023 SHALL implement FSM states IDLE, SRAM_RD, SRAM_WR, MMIO, DONE.
REQ-024 SHALL accept a request only in IDLE with cpu_mem_ena=1, latching address, wdata and direction on that edge; CPU holds inputs stable until cpu_ready.
REQ-025 SHALL on SRAM read: IDLE->SRAM_RD, drive sram_mem_ena=1, sram_wr_ena=0 for exactly SRAM_LAT cycles, capture sram_rdata into cpu_rdata on the last one, ->DONE.
REQ-026 SHALL on SRAM write: IDLE->SRAM_WR, drive sram_mem_ena=1, sram_wr_ena=1 for exactly one cycle with latched address/data, ->DONE.
REQ-027 SHALL on MMIO access: IDLE->MMIO for one cycle, perform register write or load cpu_rdata from mapped source, ->DONE; SRAM enables stay 0.
REQ-028 SHALL assert cpu_ready=1 for exactly the DONE cycle, then return to IDLE; back-to-back requests accepted from IDLE the cycle after DONE.
REQ-029 SHALL give latencies accept->cpu_ready of SRAM_LAT+1 (SRAM read), 2 (SRAM write), 2 (MMIO).
REQ-030 SHALL complete an accepted transaction even if cpu_mem_ena drops mid-operation; requests outside IDLE are ignored.
REQ-031 SHALL hold cpu_rdata unchanged except on read completion; writes never alter cpu_rdata.
REQ-032 SHALL sample sw_i in the MMIO cycle only.
REQ-033 SHALL drive sram_addr/sram_wdata from latched values; sram_mem_ena and sram_wr_ena SHALL be 0 whenever not in SRAM_RD/SRAM_WR.

Reset
REQ-034 SHALL on reset=1 immediately force IDLE, cpu_ready=0, sram_mem_ena=0, sram_wr_ena=0, cpu_rdata=0, sram_addr=0, sram_wdata=0, all hex registers=0, independent of clk.
REQ-035 SHALL abandon any in-flight transaction on reset with no cpu_ready pulse and no SRAM write.

Verification
REQ-036 SHALL verify SRAM read, SRAM_LAT=3: read 0x3000, sram_rdata=0xBEEF -> sram_mem_ena high 3 cycles, cpu_ready 4 cycles after accept, cpu_rdata=0xBEEF.
REQ-037 SHALL verify MMIO: write 0x1234 to 0xFFF1, then read 0xFFF1 -> hex_o[31:16]=0x1234, read returns 0x1234, both ready at latency 2, SRAM enables never asserted.
REQ-038 SHALL verify switch/compat: sw_i=0x00A5, read 0xFFFF -> 0x00A5; write 0x5555 to 0xFFFF -> hex_o[15:0]=0x5555.
REQ-039 SHALL verify unmapped: N_HEX=2, read 0xFFF7 -> cpu_rdata=0, ready at 2; write 0xFFF7 -> hex_o unchanged.
REQ-040 SHALL verify reset mid-op: assert reset during SRAM_RD cycle 2 -> enables drop same cycle, no cpu_ready, all outputs 0; next read after release completes normally.
REQ-041 SHALL verify drop/back-to-back: cpu_mem_ena deasserted after accept of write 0x4000 -> write still issued once; new request the cycle after cpu_ready accepted immediately.
